// File: rtl/stack_pointer_unit_pkg.sv
// rtl/stack_pointer_unit_pkg.sv - shared stack geometry and FSM state type for the Stage4 stack port
package stack_pointer_unit_pkg;

    localparam int SP_WIDTH    = 12;
    localparam int STACK_BASE  = 200;
    localparam int STACK_DEPTH = 64;
    localparam int DEPTH_W     = $clog2(STACK_DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2,
        ST_FAULT   = 2'd3
    } sp_state_t;

endpackage

// File: rtl/stack_pointer_unit_if.sv
// rtl/stack_pointer_unit_if.sv - request/qualifier bundle between decode/execute and the stack pointer unit
interface stack_pointer_unit_if #(
    parameter int SP_WIDTH = 12,
    parameter int DEPTH_W  = 7
);
    logic                CALL_flag;
    logic                RET_flag;
    logic                stall;
    logic                err_clear;
    logic [SP_WIDTH-1:0] SP_Data;
    logic                push_ok;
    logic                pop_ok;
    logic [DEPTH_W-1:0]  depth;
    logic                stack_empty;
    logic                stack_full;
    logic                overflow_err;
    logic                underflow_err;
    logic                conflict_err;

    modport master (
        output CALL_flag, RET_flag, stall, err_clear,
        input  SP_Data, push_ok, pop_ok, depth, stack_empty, stack_full,
        input  overflow_err, underflow_err, conflict_err
    );

    modport slave (
        input  CALL_flag, RET_flag, stall, err_clear,
        output SP_Data, push_ok, pop_ok, depth, stack_empty, stack_full,
        output overflow_err, underflow_err, conflict_err
    );
endinterface

// File: rtl/stack_pointer_unit.sv
// rtl/stack_pointer_unit.sv - call-stack pointer owner with push/pop qualification and sticky fault lock
module stack_pointer_unit
    import stack_pointer_unit_pkg::*;
#(
    parameter int SP_WIDTH_P    = SP_WIDTH,
    parameter int STACK_BASE_P  = STACK_BASE,
    parameter int STACK_DEPTH_P = STACK_DEPTH,
    parameter int DEPTH_W_P     = $clog2(STACK_DEPTH_P) + 1
) (
    input logic                  clk,
    input logic                  reset,
    stack_pointer_unit_if.slave  bus
);

    localparam logic [SP_WIDTH_P-1:0] BASE_V  = SP_WIDTH_P'(STACK_BASE_P);
    localparam logic [DEPTH_W_P-1:0]  DEPTH_V = DEPTH_W_P'(STACK_DEPTH_P);
    localparam logic [DEPTH_W_P-1:0]  ONE_D   = DEPTH_W_P'(1);
    localparam logic [SP_WIDTH_P-1:0] ONE_SP  = SP_WIDTH_P'(1);

    if (STACK_BASE_P + STACK_DEPTH_P > (1 << SP_WIDTH_P)) begin : g_bad_geometry
        $error("stack_pointer_unit: STACK_BASE + STACK_DEPTH exceeds SP_WIDTH address space");
    end

    logic [SP_WIDTH_P-1:0] top_q, top_d;
    logic [DEPTH_W_P-1:0]  depth_q, depth_d;
    sp_state_t             state_q, state_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  cnf_q, cnf_d;

    logic call_only, ret_only, active;
    logic push_ok, pop_ok;
    logic ovf_hit, unf_hit, cnf_hit;

    // Register all state; reset overrides everything including err_clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            top_q   <= BASE_V;
            depth_q <= '0;
            state_q <= ST_EMPTY;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            cnf_q   <= 1'b0;
        end else begin
            top_q   <= top_d;
            depth_q <= depth_d;
            state_q <= state_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            cnf_q   <= cnf_d;
        end
    end

    // Qualify requests, drive the access address, and compute next pointer/FSM/error state.
    always_comb begin
        call_only = bus.CALL_flag & ~bus.RET_flag;
        ret_only  = bus.RET_flag & ~bus.CALL_flag;
        active    = ~bus.stall & (state_q != ST_FAULT);

        push_ok = active & call_only & (state_q != ST_FULL);
        pop_ok  = active & ret_only  & (state_q != ST_EMPTY);
        ovf_hit = active & call_only & (state_q == ST_FULL);
        unf_hit = active & ret_only  & (state_q == ST_EMPTY);
        cnf_hit = active & bus.CALL_flag & bus.RET_flag;

        top_d   = top_q;
        depth_d = depth_q;
        state_d = state_q;
        ovf_d   = ovf_q | ovf_hit;
        unf_d   = unf_q | unf_hit;
        cnf_d   = cnf_q | cnf_hit;

        if (bus.err_clear) begin
            top_d   = BASE_V;
            depth_d = '0;
            state_d = ST_EMPTY;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            cnf_d   = 1'b0;
        end else if (ovf_hit | unf_hit | cnf_hit) begin
            state_d = ST_FAULT;
        end else if (push_ok) begin
            top_d   = top_q + ONE_SP;
            depth_d = depth_q + ONE_D;
            state_d = (depth_q + ONE_D == DEPTH_V) ? ST_FULL : ST_PARTIAL;
        end else if (pop_ok) begin
            top_d   = top_q - ONE_SP;
            depth_d = depth_q - ONE_D;
            state_d = (depth_q == ONE_D) ? ST_EMPTY : ST_PARTIAL;
        end

        // A pop reads the slot just below the free pointer, so push and pop of one entry share an address.
        bus.SP_Data       = ret_only ? (top_q - ONE_SP) : top_q;
        bus.push_ok       = push_ok;
        bus.pop_ok        = pop_ok;
        bus.depth         = depth_q;
        bus.stack_empty   = (depth_q == '0);
        bus.stack_full    = (depth_q == DEPTH_V);
        bus.overflow_err  = ovf_q;
        bus.underflow_err = unf_q;
        bus.conflict_err  = cnf_q;
    end

endmodule

// File: tb/tb_stack_pointer_unit.sv
// tb/tb_stack_pointer_unit.sv - directed self-checking bench for stack_pointer_unit
module tb_stack_pointer_unit;
    import stack_pointer_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    stack_pointer_unit_if #(.SP_WIDTH(SP_WIDTH), .DEPTH_W(DEPTH_W)) sp_if ();

    stack_pointer_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sp_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, return 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic r, input logic s, input logic e);
        sp_if.CALL_flag = c;
        sp_if.RET_flag  = r;
        sp_if.stall     = s;
        sp_if.err_clear = e;
        #2;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0);
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0);
        chk("rst_sp",    32'(sp_if.SP_Data), 200);
        chk("rst_depth", 32'(sp_if.depth), 0);
        chk("rst_empty", 32'(sp_if.stack_empty), 1);
        chk("rst_full",  32'(sp_if.stack_full), 0);
        chk("rst_errs",  32'({sp_if.overflow_err, sp_if.underflow_err, sp_if.conflict_err}), 0);
        chk("rst_push",  32'(sp_if.push_ok), 0);
        chk("rst_pop",   32'(sp_if.pop_ok), 0);

        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0);
            chk($sformatf("call%0d_sp", i), 32'(sp_if.SP_Data), 32'(200 + i));
            chk($sformatf("call%0d_ok", i), 32'(sp_if.push_ok), 1);
            tick();
        end
        drive(0, 0, 0, 0);
        chk("after5_depth", 32'(sp_if.depth), 5);
        chk("after5_top",   32'(sp_if.SP_Data), 205);

        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 0);
            chk($sformatf("ret%0d_sp", i), 32'(sp_if.SP_Data), 32'(204 - i));
            chk($sformatf("ret%0d_ok", i), 32'(sp_if.pop_ok), 1);
            tick();
        end
        drive(0, 0, 0, 0);
        chk("pop5_depth", 32'(sp_if.depth), 0);
        chk("pop5_empty", 32'(sp_if.stack_empty), 1);

        drive(0, 1, 0, 0);
        chk("unf_pop_ok", 32'(sp_if.pop_ok), 0);
        tick();
        drive(0, 0, 0, 0);
        chk("unf_flag", 32'(sp_if.underflow_err), 1);
        drive(1, 0, 0, 0);
        chk("fault_push_ok", 32'(sp_if.push_ok), 0);
        tick();
        drive(0, 0, 0, 0);
        chk("fault_depth", 32'(sp_if.depth), 0);
        drive(0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0);
        chk("clr_unf", 32'(sp_if.underflow_err), 0);
        chk("clr_sp",  32'(sp_if.SP_Data), 200);
        drive(1, 0, 0, 0);
        chk("clr_push_ok", 32'(sp_if.push_ok), 1);

        for (int i = 0; i < 64; i++) begin
            drive(1, 0, 0, 0);
            if (i == 63) begin
                chk("fill_last_sp", 32'(sp_if.SP_Data), 263);
                chk("fill_last_ok", 32'(sp_if.push_ok), 1);
            end
            tick();
        end
        drive(0, 0, 0, 0);
        chk("full_flag",  32'(sp_if.stack_full), 1);
        chk("full_depth", 32'(sp_if.depth), 64);
        drive(1, 0, 0, 0);
        chk("ovf_push_ok", 32'(sp_if.push_ok), 0);
        chk("ovf_sp",      32'(sp_if.SP_Data), 264);
        tick();
        drive(0, 0, 0, 0);
        chk("ovf_flag",  32'(sp_if.overflow_err), 1);
        chk("ovf_sp_after", 32'(sp_if.SP_Data), 264);
        drive(0, 1, 0, 0);
        chk("fault_pop_ok", 32'(sp_if.pop_ok), 0);
        tick();
        drive(0, 0, 0, 0);
        chk("fault_depth_frozen", 32'(sp_if.depth), 64);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0);
            tick();
        end
        drive(1, 1, 0, 0);
        chk("cnf_push_ok", 32'(sp_if.push_ok), 0);
        chk("cnf_pop_ok",  32'(sp_if.pop_ok), 0);
        chk("cnf_sp",      32'(sp_if.SP_Data), 203);
        tick();
        drive(0, 0, 0, 0);
        chk("cnf_flag",  32'(sp_if.conflict_err), 1);
        chk("cnf_depth", 32'(sp_if.depth), 3);
        drive(0, 0, 0, 1);
        tick();

        drive(1, 0, 1, 0);
        chk("stall_push_ok", 32'(sp_if.push_ok), 0);
        tick();
        drive(0, 1, 1, 0);
        chk("stall_pop_ok", 32'(sp_if.pop_ok), 0);
        tick();
        drive(0, 0, 0, 0);
        chk("stall_depth", 32'(sp_if.depth), 0);
        chk("stall_errs",  32'({sp_if.overflow_err, sp_if.underflow_err, sp_if.conflict_err}), 0);

        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0);
        chk("mid_depth2", 32'(sp_if.depth), 2);
        drive(1, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0);
        chk("mid_rst_sp",    32'(sp_if.SP_Data), 200);
        chk("mid_rst_depth", 32'(sp_if.depth), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
